// File: rtl/axis_stream2bram_slave_pkg.sv
// Shared types for the AXI4-Stream to BRAM sink: FSM state encoding.
package axis_stream2bram_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

endpackage

// File: rtl/axis_stream2bram_slave_if.sv
// AXI4-Stream beat bundle with master/slave views.
interface axis_stream2bram_slave_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, output tstrb, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tstrb, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis2bram_wr_stage.sv
// One-entry BRAM write stage: holds addr/data/we while the BRAM port stalls.
module axis2bram_wr_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [DATA_W-1:0]   load_data,
  input  logic [DATA_W/8-1:0] load_we,
  input  logic                ready,
  output logic                pending,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   data,
  output logic [DATA_W/8-1:0] we,
  output logic                retire
);

  assign retire = pending && ready;

  // A load in the same cycle as a retire refills the stage, keeping 1 word/clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      addr    <= '0;
      data    <= '0;
      we      <= '0;
    end else if (load) begin
      pending <= 1'b1;
      addr    <= load_addr;
      data    <= load_data;
      we      <= load_we;
    end else if (retire) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_stream2bram_slave.sv
// AXI4-Stream sink writing one frame into BRAM from address 0.
// Optional checksum output enabled by defining AXIS2BRAM_CHECKSUM_EN.
module axis_stream2bram_slave
  import axis_stream2bram_slave_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int DST_ADDR_WIDTH       = 12,
  parameter int DST_ADDR_MAX         = 1024
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  axis_stream2bram_slave_if.slave           s_axis,
  input  logic                              start,
  output logic [DST_ADDR_WIDTH-1:0]         dst_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   dst_data,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] dst_we,
  output logic                              dst_enable,
  input  logic                              dst_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow,
  output logic [DST_ADDR_WIDTH:0]           word_count
`ifdef AXIS2BRAM_CHECKSUM_EN
  ,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   checksum
`endif
);

  localparam int AW = DST_ADDR_WIDTH;
  localparam logic [AW:0] LAST_ADDR = (AW+1)'(DST_ADDR_MAX - 1);
  localparam logic [AW:0] MAX_CNT   = (AW+1)'(DST_ADDR_MAX);

  state_t      state;
  logic [AW:0] addr_cnt;
  logic        pending;
  logic        retire;
  logic        accept;
  logic        load;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    return (v >= MAX_CNT) ? v : v + 1'b1;
  endfunction

  assign s_axis.tready = ((state == ST_RECV) && (!pending || dst_ready)) || (state == ST_DISCARD);
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign load          = (state == ST_RECV) && accept;
  assign busy          = (state != ST_IDLE);
  assign dst_enable    = pending;

  axis2bram_wr_stage #(
    .DATA_W (C_S_AXIS_TDATA_WIDTH),
    .ADDR_W (AW)
  ) u_wr_stage (
    .clk       (S_AXIS_ACLK),
    .rst_n     (S_AXIS_ARESETN),
    .load      (load),
    .load_addr (addr_cnt[AW-1:0]),
    .load_data (s_axis.tdata),
    .load_we   (s_axis.tstrb),
    .ready     (dst_ready),
    .pending   (pending),
    .addr      (dst_addr),
    .data      (dst_data),
    .we        (dst_we),
    .retire    (retire)
  );

  // Entering DISCARD means a non-final beat filled the last address: frame is too long.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state      <= ST_IDLE;
      addr_cnt   <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (retire) word_count <= sat_inc(word_count);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RECV;
            addr_cnt   <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
          end
        end
        ST_RECV: begin
          if (accept) begin
            addr_cnt <= addr_cnt + 1'b1;
            if (s_axis.tlast) begin
              state <= ST_DRAIN;
            end else if (addr_cnt == LAST_ADDR) begin
              state    <= ST_DISCARD;
              overflow <= 1'b1;
            end
          end
        end
        ST_DISCARD: begin
          if (accept && s_axis.tlast) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!pending) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXIS2BRAM_CHECKSUM_EN
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      checksum <= '0;
    end else if ((state == ST_IDLE) && start) begin
      checksum <= '0;
    end else if (retire) begin
      checksum <= checksum ^ dst_data;
    end
  end
`endif

endmodule
